// File: rtl/al4s3b_fpga_wb_interconnect.sv
// Wishbone interconnect for the AL4S3B FPGA fabric: decodes one master onto NUM_SLAVES apertures
// and answers unmapped or timed-out accesses itself with a default-data ACK and error status.
module al4s3b_fpga_wb_interconnect #(
    parameter int unsigned NUM_SLAVES = 4,
    parameter int unsigned APERWIDTH = 17,
    parameter int unsigned APERSIZE = 10,
    parameter logic [NUM_SLAVES*APERWIDTH-1:0] BASE_ADDRS =
        {17'h04000, 17'h03000, 17'h02000, 17'h01000},
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter logic [31:0] DEFAULT_READ_VALUE = 32'hBADFABAC
) (
    input  logic                       WBs_CLK_i,
    input  logic                       WBs_RST_n_i,
    input  logic [APERWIDTH-1:0]       WBs_ADR_i,
    input  logic                       WBs_CYC_i,
    input  logic                       WBs_STB_i,
    output logic [31:0]                WBs_RD_DAT_o,
    output logic                       WBs_ACK_o,
    output logic [NUM_SLAVES-1:0]      WBs_CYC_s_o,
    input  logic [NUM_SLAVES-1:0]      WBs_ACK_s_i,
    input  logic [NUM_SLAVES*32-1:0]   WBs_DAT_s_i,
    input  logic                       err_clr_i,
    output logic                       err_intr_o,
    output logic                       err_type_o,
    output logic [APERWIDTH-1:0]       err_adr_o,
    output logic [7:0]                 err_cnt_o
);

    localparam int unsigned SelW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int unsigned TagW = APERWIDTH - APERSIZE;

    typedef enum logic [1:0] {StIdle, StWait, StErr, StDone} state_e;

    state_e               state_q, state_d;
    logic [SelW-1:0]      sel_q, sel_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [APERWIDTH-1:0] adr_q, adr_d;
    logic                 type_q, type_d;
    logic                 err_intr_q, err_intr_d;
    logic                 err_type_q, err_type_d;
    logic [APERWIDTH-1:0] err_adr_q, err_adr_d;
    logic [7:0]           err_cnt_q, err_cnt_d;

    logic                 hit;
    logic [SelW-1:0]      hit_idx;
    logic                 sel_ack;
    logic [31:0]          sel_dat;

    // Descending scan so the lowest matching index is the one that sticks.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (WBs_ADR_i[APERWIDTH-1:APERSIZE] == BASE_ADDRS[i*APERWIDTH+APERSIZE +: TagW]) begin
                hit     = 1'b1;
                hit_idx = SelW'(i);
            end
        end
    end

    assign sel_ack = WBs_ACK_s_i[sel_q];
    assign sel_dat = WBs_DAT_s_i[32*sel_q +: 32];

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        cnt_d        = '0;
        adr_d        = adr_q;
        type_d       = type_q;
        err_intr_d   = err_intr_q;
        err_type_d   = err_type_q;
        err_adr_d    = err_adr_q;
        err_cnt_d    = err_cnt_q;
        WBs_ACK_o    = 1'b0;
        WBs_RD_DAT_o = DEFAULT_READ_VALUE;
        WBs_CYC_s_o  = '0;

        if (err_clr_i) begin
            err_intr_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (WBs_CYC_i && WBs_STB_i) begin
                    adr_d = WBs_ADR_i;
                    if (hit) begin
                        sel_d   = hit_idx;
                        state_d = StWait;
                    end else begin
                        type_d  = 1'b0;
                        state_d = StErr;
                    end
                end
            end
            StWait: begin
                // cnt_d counts the current cycle, so a slave ACK on the last allowed cycle wins.
                cnt_d        = cnt_q + 8'd1;
                WBs_RD_DAT_o = sel_dat;
                if (!WBs_CYC_i) begin
                    state_d = StIdle;
                end else begin
                    WBs_CYC_s_o = NUM_SLAVES'(1) << sel_q;
                    WBs_ACK_o   = sel_ack;
                    if (sel_ack) begin
                        state_d = StDone;
                    end else if (cnt_d == 8'(TIMEOUT_CYCLES)) begin
                        type_d  = 1'b1;
                        state_d = StErr;
                    end
                end
            end
            StErr: begin
                WBs_ACK_o  = 1'b1;
                err_intr_d = 1'b1;
                err_type_d = type_q;
                err_adr_d  = adr_q;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
        if (!WBs_RST_n_i) begin
            state_q    <= StIdle;
            sel_q      <= '0;
            cnt_q      <= '0;
            adr_q      <= '0;
            type_q     <= 1'b0;
            err_intr_q <= 1'b0;
            err_type_q <= 1'b0;
            err_adr_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            adr_q      <= adr_d;
            type_q     <= type_d;
            err_intr_q <= err_intr_d;
            err_type_q <= err_type_d;
            err_adr_q  <= err_adr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign err_intr_o = err_intr_q;
    assign err_type_o = err_type_q;
    assign err_adr_o  = err_adr_q;
    assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_al4s3b_fpga_wb_interconnect.sv
// Randomized and directed bench for the Wishbone interconnect; each access is predicted from the
// address map and slave latency, then compared cycle by cycle against the DUT.
module tb_al4s3b_fpga_wb_interconnect;

    localparam int NS = 4;
    localparam int AW = 17;
    localparam int AS = 10;
    localparam int TO = 15;
    localparam logic [31:0] DEF = 32'hBADFABAC;
    localparam logic [NS*AW-1:0] BASES = {17'h04000, 17'h03000, 17'h02000, 17'h01000};

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [AW-1:0]     adr_i = '0;
    logic              cyc = 1'b0;
    logic              stb = 1'b0;
    logic [31:0]       rd_dat;
    logic              ack;
    logic [NS-1:0]     cyc_s;
    logic [NS-1:0]     ack_s = '0;
    logic [NS*32-1:0]  dat_s = '0;
    logic              err_clr = 1'b0;
    logic              err_intr;
    logic              err_type;
    logic [AW-1:0]     err_adr;
    logic [7:0]        err_cnt;

    int n_checks = 0;
    int n_pass = 0;

    logic [AW-1:0] base_a [NS] = '{17'h01000, 17'h02000, 17'h03000, 17'h04000};
    logic [31:0]   sdat [NS];

    // Reference error status
    bit            m_intr = 0;
    bit            m_type = 0;
    logic [AW-1:0] m_adr = '0;
    int            m_cnt = 0;

    always #5 clk = ~clk;

    al4s3b_fpga_wb_interconnect #(
        .NUM_SLAVES(NS),
        .APERWIDTH(AW),
        .APERSIZE(AS),
        .BASE_ADDRS(BASES),
        .TIMEOUT_CYCLES(TO),
        .DEFAULT_READ_VALUE(DEF)
    ) dut (
        .WBs_CLK_i(clk),
        .WBs_RST_n_i(rst_n),
        .WBs_ADR_i(adr_i),
        .WBs_CYC_i(cyc),
        .WBs_STB_i(stb),
        .WBs_RD_DAT_o(rd_dat),
        .WBs_ACK_o(ack),
        .WBs_CYC_s_o(cyc_s),
        .WBs_ACK_s_i(ack_s),
        .WBs_DAT_s_i(dat_s),
        .err_clr_i(err_clr),
        .err_intr_o(err_intr),
        .err_type_o(err_type),
        .err_adr_o(err_adr),
        .err_cnt_o(err_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    function automatic int find_slave(input logic [AW-1:0] a);
        for (int i = 0; i < NS; i++) begin
            if ((a >> AS) == (base_a[i] >> AS)) return i;
        end
        return -1;
    endfunction

    task automatic load_data();
        for (int i = 0; i < NS; i++) begin
            sdat[i] = $urandom;
            dat_s[i*32 +: 32] = sdat[i];
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, ".intr"}, 64'(err_intr), 64'(m_intr));
        check({tag, ".type"}, 64'(err_type), 64'(m_type));
        check({tag, ".eadr"}, 64'(err_adr), 64'(m_adr));
        check({tag, ".ecnt"}, 64'(err_cnt), 64'(m_cnt));
    endtask

    // One master access; the addressed slave ACKs after 'lat' selected cycles, other slaves may
    // assert stray ACKs, and err_clr is pulsed on cycle 'clr_at' (negative = never).
    task automatic do_access(input string tag, input logic [AW-1:0] a, input int lat,
                             input bit rogue, input int clr_at);
        int s, exp_c, ack_c, n_ack, bad_sel, sel_cnt;
        bit exp_err, exp_ty;
        logic [31:0] exp_dat, ack_dat;
        logic [NS-1:0] exp_sel, sel_or, rog;
        load_data();
        s = find_slave(a);
        exp_ty = 0;
        if (s < 0) begin
            exp_c = 1; exp_dat = DEF; exp_err = 1; exp_sel = '0;
        end else if (1 + lat <= TO) begin
            exp_c = 1 + lat; exp_dat = sdat[s]; exp_err = 0; exp_sel = NS'(1) << s;
        end else begin
            exp_c = TO + 1; exp_dat = DEF; exp_err = 1; exp_ty = 1; exp_sel = NS'(1) << s;
        end
        ack_c = -1; n_ack = 0; bad_sel = 0; sel_cnt = 0; sel_or = '0; ack_dat = '0;
        for (int c = 0; c < TO + 6; c++) begin
            @(negedge clk);
            if (c == 0) begin
                adr_i = a; cyc = 1'b1; stb = 1'b1;
            end else if (ack_c >= 0) begin
                cyc = 1'b0; stb = 1'b0;
            end
            err_clr = (c == clr_at);
            #1;
            rog = rogue ? NS'($urandom) : '0;
            if (s >= 0) begin
                rog[s] = 1'b0;
                if (cyc_s[s]) begin
                    if (sel_cnt == lat) rog[s] = 1'b1;
                    sel_cnt++;
                end
            end
            ack_s = rog;
            #1;
            if (ack) begin
                n_ack++;
                if (ack_c < 0) begin ack_c = c; ack_dat = rd_dat; end
            end
            sel_or |= cyc_s;
            if (cyc_s != '0 && cyc_s != exp_sel) bad_sel++;
            if (exp_err && c == exp_c) begin
                m_intr = 1; m_type = exp_ty; m_adr = a;
                if (m_cnt < 255) m_cnt++;
            end else if (c == clr_at) begin
                m_intr = 0;
            end
        end
        err_clr = 1'b0;
        ack_s = '0;
        check({tag, ".nack"}, 64'(n_ack), 64'(1));
        check({tag, ".lat"}, 64'(ack_c), 64'(exp_c));
        check({tag, ".data"}, 64'(ack_dat), 64'(exp_dat));
        check({tag, ".sel"}, 64'(sel_or), 64'(exp_sel));
        check({tag, ".badsel"}, 64'(bad_sel), 64'(0));
        check_status(tag);
    endtask

    task automatic do_abort(input string tag, input logic [AW-1:0] a, input int drop_c);
        int n_ack, bad;
        n_ack = 0; bad = 0;
        for (int c = 0; c < TO + 6; c++) begin
            @(negedge clk);
            if (c == 0) begin adr_i = a; cyc = 1'b1; stb = 1'b1; end
            if (c == drop_c) begin cyc = 1'b0; stb = 1'b0; end
            #1;
            if (ack) n_ack++;
            if (c >= drop_c && cyc_s != '0) bad++;
        end
        check({tag, ".nack"}, 64'(n_ack), 64'(0));
        check({tag, ".seloff"}, 64'(bad), 64'(0));
        check_status(tag);
    endtask

    task automatic do_reset_mid(input string tag, input logic [AW-1:0] a, input int at_c);
        int s;
        s = find_slave(a);
        for (int c = 0; c <= at_c; c++) begin
            @(negedge clk);
            if (c == 0) begin adr_i = a; cyc = 1'b1; stb = 1'b1; end
        end
        #1;
        check({tag, ".selon"}, 64'(cyc_s), 64'(NS'(1) << s));
        rst_n = 1'b0;
        ack_s[s] = 1'b1;
        #1;
        m_intr = 0; m_type = 0; m_adr = '0; m_cnt = 0;
        check({tag, ".ack"}, 64'(ack), 64'(0));
        check({tag, ".sel"}, 64'(cyc_s), 64'(0));
        check({tag, ".rd"}, 64'(rd_dat), 64'(DEF));
        check_status(tag);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; ack_s = '0; rst_n = 1'b1;
    endtask

    initial begin
        logic [AW-1:0] a;
        int k;
        repeat (2) @(negedge clk);
        #1;
        check("rst.ack", 64'(ack), 64'(0));
        check("rst.sel", 64'(cyc_s), 64'(0));
        check("rst.rd", 64'(rd_dat), 64'(DEF));
        check_status("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed scenarios
        do_access("hit_s2", 17'h03004, 2, 0, -1);
        do_access("unmapped", 17'h07000, 0, 0, -1);
        do_access("timeout", 17'h01000, 255, 0, -1);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0; m_intr = 0;
        #1;
        check("clr.intr", 64'(err_intr), 64'(0));
        check("clr.cnt", 64'(err_cnt), 64'(m_cnt));
        do_access("rogue_s1", 17'h02010, 3, 1, -1);
        do_access("edge_ack", 17'h01000, TO - 1, 0, -1);
        do_access("edge_to", 17'h01000, TO, 0, -1);
        do_abort("abort", 17'h02000, 3);
        do_access("post_abort", 17'h02000, 1, 0, -1);
        do_reset_mid("midrst", 17'h03000, 2);
        do_access("post_rst", 17'h02000, 0, 0, -1);

        // Saturation, then clear colliding with an error update
        for (int i = 0; i < 299; i++) begin
            do_access("sat", 17'h07000 | AW'($urandom_range(0, 1023)), 0, 1'($urandom), -1);
        end
        do_access("sat_clr", 17'h07000, 0, 0, 1);

        // Randomized mix
        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 4);
            if (k == 4) a = 17'h10000 | AW'($urandom_range(0, 16'hFFFF));
            else a = base_a[k] + AW'($urandom_range(0, 1023));
            do_access("rand", a, $urandom_range(0, TO + 2), 1'($urandom),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TO + 4)) : -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
